hex_word_serializer: RTL and testbench

//   Serializes a 4*NIBBLES-bit word into a stream of 7-bit ASCII hex characters, most significant nibble first.

---
 rtl/hex_word_serializer.sv | 108 ++++++++++
 tb/tb_hex_word_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hex_word_serializer.sv
// Serializes a 4*NIBBLES-bit word into uppercase ASCII hex characters, MS nibble first.
// Optional CR/LF terminator after each word when HEXSER_CRLF_EN is defined.
module hex_word_serializer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6:0]           out_char,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

`ifdef HEXSER_CRLF_EN
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_CR, S_LF} state_t;
`else
    typedef enum logic {S_IDLE, S_EMIT} state_t;
`endif

    function automatic logic [6:0] nib_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 7'h30 + {3'b000, nib};
        else
            return 7'h37 + {3'b000, nib};
    endfunction

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic [CW-1:0]   r_count;
    logic            r_out_valid;
    logic [6:0]      r_out_char;
    logic [W-1:0]    w_shift_next;
    logic            w_out_fire;

    assign w_shift_next = r_shift << 4;
    assign w_out_fire   = r_out_valid && out_ready;

    // in_ready and busy depend on the state register only.
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_char  <= 7'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift     <= in_data;
                        r_count     <= CW'(NIBBLES - 1);
                        r_out_char  <= nib_to_ascii(in_data[W-1 -: 4]);
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_out_fire) begin
                        if (r_count != '0) begin
                            // Next digit comes from the shifted word so it lands on the same edge.
                            r_shift    <= w_shift_next;
                            r_count    <= r_count - 1'b1;
                            r_out_char <= nib_to_ascii(w_shift_next[W-1 -: 4]);
                        end else begin
`ifdef HEXSER_CRLF_EN
                            r_out_char <= 7'h0D;
                            r_state    <= S_CR;
`else
                            r_out_valid <= 1'b0;
                            r_state     <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef HEXSER_CRLF_EN
                S_CR: begin
                    if (w_out_fire) begin
                        r_out_char <= 7'h0A;
                        r_state    <= S_LF;
                    end
                end
                S_LF: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_word_serializer.sv
// Scoreboard bench for hex_word_serializer: stimulus pushes expected characters,
// a negedge monitor pops and compares on every accepted output character.
module tb_hex_word_serializer;

    localparam int NIB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4*NIB-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_char;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int seen   = 0;
    logic [6:0] exp_q[$];

    hex_word_serializer #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_char (out_char),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Hand-written expected characters per test word.
    task automatic push_chars(input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3);
        exp_q.push_back(c0); exp_q.push_back(c1);
        exp_q.push_back(c2); exp_q.push_back(c3);
        pushed += 4;
`ifdef HEXSER_CRLF_EN
        exp_q.push_back(7'h0D); exp_q.push_back(7'h0A);
        pushed += 2;
`endif
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Waits for in_ready (sampled 1 time unit after an edge) with a cycle budget.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL %s: in_ready timeout actual=0 required=1", name);
        end
    endtask

    // Handshake one word; returns 1 time unit after the capturing edge.
    task automatic send_word(input logic [15:0] d, input string name);
        wait_ready(name);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: one line per accepted character.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [6:0] e;
            seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL char: unexpected actual=%02h required=none", out_char);
            end else begin
                e = exp_q.pop_front();
                if (out_char !== e) begin
                    errors++;
                    $display("FAIL char: actual=%02h required=%02h", out_char, e);
                end else begin
                    $display("char %02h", out_char);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_char",  32'(out_char),  32'h00);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // 2: full rate, latency and word-to-word timing
        push_chars(7'h30, 7'h39, 7'h41, 7'h46);
        send_word(16'h09AF, "t2");
        check("t2_first_valid", 32'(out_valid), 32'd1);
        check("t2_first_char",  32'(out_char),  32'h30);
        check("t2_in_ready_busy", 32'(in_ready), 32'd0);
`ifdef HEXSER_CRLF_EN
        repeat (5) @(posedge clk);
`else
        repeat (3) @(posedge clk);
`endif
        #1 check("t2_busy_last", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t2_in_ready_after", 32'(in_ready), 32'd1);
        check("t2_out_valid_after", 32'(out_valid), 32'd0);

        // 3: backpressure on the 2nd character
        push_chars(7'h31, 7'h32, 7'h33, 7'h34);
        send_word(16'h1234, "t3");
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_char", 32'(out_char), 32'h32);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_ready("t3_done");

        // 4: in_valid held with different data while busy
        push_chars(7'h35, 7'h41, 7'h35, 7'h41);
        push_chars(7'h37, 7'h37, 7'h37, 7'h37);
        send_word(16'h5A5A, "t4a");
        in_valid = 1'b1;
        in_data  = 16'h7777;
        @(posedge clk); #1;
        check("t4_in_ready_busy", 32'(in_ready), 32'd0);
        wait_ready("t4b");
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ready("t4_done");

        // 5: reset while the 3rd character of BEEF is pending
        push_chars(7'h42, 7'h45, 7'h45, 7'h46);
        send_word(16'hBEEF, "t5");
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5_pending_char", 32'(out_char), 32'h45);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
`ifdef HEXSER_CRLF_EN
        pushed -= 4;
`else
        pushed -= 2;
`endif
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready",  32'(in_ready),  32'd1);
        check("t5_busy",      32'(busy),      32'd0);
        out_ready = 1'b1;
        push_chars(7'h30, 7'h30, 7'h30, 7'h30);
        send_word(16'h0000, "t5b");
        wait_ready("t5b_done");

        // 6: terminator behaviour depends on the build
        push_chars(7'h43, 7'h44, 7'h45, 7'h46);
        send_word(16'hCDEF, "t6");
        wait_ready("t6_done");

        repeat (3) @(posedge clk); #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("char_count",  32'(seen), 32'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
